// File: rtl/param_pipe_core.sv
// param_pipe_core: 4-stage (IF/ID/EX/WB) 16-bit-instruction core with an
// NUM_REGS x DATA_W register file, IMEM_DEPTH x 16 instruction memory and
// DMEM_DEPTH x DATA_W data memory. Build option: define PIPE_CORE_FWD_EN to
// forward EX/WB results into ID operands; without it, RAW hazards stall ID.
// Ports: clk, rst_n (async active-low); run (level, 1 = execute, 0 = idle /
// program load); imem_we/imem_waddr/imem_wdata (instruction load, IDLE only);
// dbg_raddr/dbg_rdata (combinational register peek, 0 beyond NUM_REGS);
// pc (fetch address); halted (HALT state); retired (saturating count of
// retired non-bubble, non-HALT instructions, cleared when a run starts).
// Instruction: opcode[15:13] rd[12:10] rs[9:7] imm[6:0].
// 000 ADD, 001 SUB, 010 LOAD, 011 STORE, 100 ADDI, 111 HALT, others NOP.

module param_pipe_core #(
  parameter int DATA_W     = 8,
  parameter int NUM_REGS   = 4,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [15:0]                   imem_wdata,
  input  logic [2:0]                    dbg_raddr,
  output logic [DATA_W-1:0]             dbg_rdata,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic                          halted,
  output logic [15:0]                   retired
);

  localparam int IA = $clog2(IMEM_DEPTH);
  localparam int DA = $clog2(DMEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

  // Decoded operation; K_NOP also covers opcodes naming a nonexistent register.
  typedef enum logic [2:0] {
    K_NOP, K_ADD, K_SUB, K_LOAD, K_STORE, K_ADDI, K_HALT
  } kind_e;

  typedef struct packed {
    logic        vld;
    logic [15:0] ins;
  } ifid_t;

  typedef struct packed {
    logic              vld;
    kind_e             kind;
    logic [2:0]        rd;
    logic [DATA_W-1:0] a;     // rd value (also STORE data)
    logic [DATA_W-1:0] b;     // rs value or zero-extended imm
    logic [DA-1:0]     addr;  // imm truncated to the data-memory range
  } idex_t;

  typedef struct packed {
    logic              vld;   // non-bubble, non-HALT: counts as retired
    logic              we;
    logic [2:0]        rd;
    logic [DATA_W-1:0] val;
  } exwb_t;

  state_e            state_q, state_d;
  logic [IA-1:0]     pc_q, pc_d;
  logic [15:0]       ret_q, ret_d;
  ifid_t             ifid_q, ifid_d;
  idex_t             idex_q, idex_d;
  exwb_t             exwb_q, exwb_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [15:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  // Pipeline only advances (and only commits writes) in RUN with run held.
  logic go;
  assign go = (state_q == S_RUN) && run;

  // ---------------- ID: decode ----------------
  logic [2:0] id_op, id_rd, id_rs;
  logic       id_rd_ok, id_rs_ok;
  kind_e      id_kind;
  logic       id_use_rd, id_use_rs;

  assign id_op    = ifid_q.ins[15:13];
  assign id_rd    = ifid_q.ins[12:10];
  assign id_rs    = ifid_q.ins[9:7];
  assign id_rd_ok = int'(id_rd) < NUM_REGS;
  assign id_rs_ok = int'(id_rs) < NUM_REGS;

  always_comb begin
    id_kind = K_NOP;
    if (ifid_q.vld) begin
      case (id_op)
        3'b000:  if (id_rd_ok && id_rs_ok) id_kind = K_ADD;
        3'b001:  if (id_rd_ok && id_rs_ok) id_kind = K_SUB;
        3'b010:  if (id_rd_ok) id_kind = K_LOAD;
        3'b011:  if (id_rd_ok) id_kind = K_STORE;
        3'b100:  if (id_rd_ok) id_kind = K_ADDI;
        3'b111:  id_kind = K_HALT;
        default: id_kind = K_NOP;
      endcase
    end
    // rd is a source for everything that reads it; rs only for ADD/SUB.
    id_use_rd = id_kind inside {K_ADD, K_SUB, K_STORE, K_ADDI};
    id_use_rs = id_kind inside {K_ADD, K_SUB};
  end

  // ---------------- hazard detection ----------------
  logic ex_wr, wb_wr, wb_we;
  logic a_ex, a_wb, b_ex, b_wb;

  assign ex_wr = idex_q.vld && (idex_q.kind inside {K_ADD, K_SUB, K_LOAD, K_ADDI});
  assign wb_wr = exwb_q.vld && exwb_q.we;
  assign wb_we = go && wb_wr;

  assign a_ex = id_use_rd && ex_wr && (idex_q.rd == id_rd);
  assign a_wb = id_use_rd && wb_wr && (exwb_q.rd == id_rd);
  assign b_ex = id_use_rs && ex_wr && (idex_q.rd == id_rs);
  assign b_wb = id_use_rs && wb_wr && (exwb_q.rd == id_rs);

  // ---------------- register read with WB write-through ----------------
  logic [DATA_W-1:0] rf_a, rf_b;

  always_comb begin
    rf_a = '0;
    rf_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (id_rd == i[2:0]) rf_a = regs_q[i];
      if (id_rs == i[2:0]) rf_b = regs_q[i];
    end
    if (wb_we && (exwb_q.rd == id_rd)) rf_a = exwb_q.val;
    if (wb_we && (exwb_q.rd == id_rs)) rf_b = exwb_q.val;
  end

  // ---------------- EX ----------------
  logic [DATA_W-1:0] ex_res;
  logic              ex_halt, dmem_we;

  always_comb begin
    ex_res = '0;
    case (idex_q.kind)
      K_ADD, K_ADDI: ex_res = idex_q.a + idex_q.b;
      K_SUB:         ex_res = idex_q.a - idex_q.b;
      // Combinational read: a STORE committed last cycle is already visible.
      K_LOAD:        ex_res = dmem[idex_q.addr];
      default:       ex_res = '0;
    endcase
  end

  assign ex_halt = idex_q.vld && (idex_q.kind == K_HALT);
  assign dmem_we = go && idex_q.vld && (idex_q.kind == K_STORE);

  // ---------------- operand select / stall ----------------
  logic [DATA_W-1:0] opnd_a, opnd_rs, opnd_b;
  logic              id_stall;

`ifdef PIPE_CORE_FWD_EN
  // Youngest producer wins: EX result over WB result over register file.
  assign opnd_a   = a_ex ? ex_res : (a_wb ? exwb_q.val : rf_a);
  assign opnd_rs  = b_ex ? ex_res : (b_wb ? exwb_q.val : rf_b);
  assign id_stall = 1'b0;
`else
  // A WB match also stalls, so a back-to-back dependency costs two cycles.
  assign opnd_a   = rf_a;
  assign opnd_rs  = rf_b;
  assign id_stall = a_ex | a_wb | b_ex | b_wb;
`endif

  assign opnd_b = (id_kind == K_ADDI) ? {{(DATA_W-7){1'b0}}, ifid_q.ins[6:0]} : opnd_rs;

  // ---------------- FSM next state and pipeline advance ----------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    ifid_d  = ifid_q;
    idex_d  = idex_q;
    exwb_d  = exwb_q;

    case (state_q)
      S_IDLE: begin
        pc_d   = '0;
        ifid_d = '0;
        idex_d = '0;
        exwb_d = '0;
        if (run) begin
          state_d = S_RUN;
          ret_d   = '0;
        end
      end

      S_RUN: begin
        if (!run) begin
          // Abandon whatever is in flight; register file is kept.
          state_d = S_IDLE;
          pc_d    = '0;
          ifid_d  = '0;
          idex_d  = '0;
          exwb_d  = '0;
        end else begin
          if (exwb_q.vld && (ret_q != 16'hFFFF)) ret_d = ret_q + 16'd1;

          exwb_d.vld = idex_q.vld && !ex_halt;
          exwb_d.we  = idex_q.vld && (idex_q.kind inside {K_ADD, K_SUB, K_LOAD, K_ADDI});
          exwb_d.rd  = idex_q.rd;
          exwb_d.val = ex_res;

          if (ex_halt) begin
            // Everything younger than HALT is squashed; the older one in WB
            // commits on this same edge.
            state_d = S_HALT;
            ifid_d  = '0;
            idex_d  = '0;
          end else if (id_stall) begin
            idex_d = '0;
          end else begin
            idex_d.vld  = ifid_q.vld;
            idex_d.kind = id_kind;
            idex_d.rd   = id_rd;
            idex_d.a    = opnd_a;
            idex_d.b    = opnd_b;
            idex_d.addr = ifid_q.ins[DA-1:0];
            ifid_d.vld  = 1'b1;
            ifid_d.ins  = imem[pc_q];
            pc_d        = pc_q + IA'(1);
          end
        end
      end

      S_HALT: begin
        ifid_d = '0;
        idex_d = '0;
        exwb_d = '0;
        if (!run) begin
          state_d = S_IDLE;
          pc_d    = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
        ifid_d  = '0;
        idex_d  = '0;
        exwb_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ret_q   <= '0;
      ifid_q  <= '0;
      idex_q  <= '0;
      exwb_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exwb_q  <= exwb_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wb_we && (exwb_q.rd == i[2:0])) regs_q[i] <= exwb_q.val;
      end
    end
  end

  // Memories are not reset; reset only clears the core state.
  always_ff @(posedge clk) begin
    if (imem_we && (state_q == S_IDLE)) imem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (dmem_we) dmem[idex_q.addr] <= idex_q.a;
  end

  // ---------------- outputs ----------------
  always_comb begin
    dbg_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (dbg_raddr == i[2:0]) dbg_rdata = regs_q[i];
    end
  end

  assign pc      = pc_q;
  assign halted  = (state_q == S_HALT);
  assign retired = ret_q;

endmodule

// File: tb/tb_param_pipe_core.sv
module tb_param_pipe_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_we = 1'b0;
  logic [3:0]  imem_waddr = '0;
  logic [15:0] imem_wdata = '0;
  logic [2:0]  dbg_raddr = '0;
  logic [7:0]  dbg_rdata;
  logic [3:0]  pc;
  logic        halted;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;

  param_pipe_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata),
    .pc         (pc),
    .halted     (halted),
    .retired    (retired)
  );

  always #5 clk = ~clk;

`ifdef PIPE_CORE_FWD_EN
  localparam int CYC_A = 6;
`else
  localparam int CYC_A = 8;  // two extra cycles stalled on the R1 dependency
`endif

  localparam logic [15:0] NOP  = 16'hA000;
  localparam logic [15:0] HALT = 16'hE000;

  typedef struct packed {
    logic [7:0][15:0] prog;
    logic [3:0][7:0]  exp_r;
    logic [15:0]      exp_ret;
    logic [7:0]       exp_cyc;  // 0: cycle count not checked
  } vec_t;

  vec_t vecs [3];

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [6:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic rd_reg(input int r, output logic [7:0] v);
    dbg_raddr = r[2:0];
    #1;
    v = dbg_rdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run = 1'b0;
    imem_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_prog(input logic [7:0][15:0] p);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      imem_we = 1'b1;
      imem_waddr = i[3:0];
      imem_wdata = (i < 8) ? p[i] : NOP;
    end
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  // Counts rising edges from the IDLE->RUN edge (n=1) until halted is seen.
  task automatic run_to_halt(output int n);
    @(negedge clk);
    run = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!halted && n < 500);
  endtask

  task automatic drop_run(input string tag);
    @(negedge clk);
    run = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_idle_halted"}, {31'b0, halted}, 32'd0);
    chk({tag, "_idle_pc"}, {28'b0, pc}, 32'd0);
  endtask

  initial begin
    logic [7:0] v;
    int n;

    // ---- vector table ----
    for (int k = 0; k < 3; k++) vecs[k].prog = {8{NOP}};
    // ADDI R1,5; ADDI R1,3; HALT
    vecs[0].prog[0] = enc(3'b100, 3'd1, 3'd0, 7'd5);
    vecs[0].prog[1] = enc(3'b100, 3'd1, 3'd0, 7'd3);
    vecs[0].prog[2] = HALT;
    vecs[0].exp_r   = {8'h00, 8'h00, 8'h08, 8'h00};
    vecs[0].exp_ret = 16'd2;
    vecs[0].exp_cyc = 8'(CYC_A);
    // dmem[2]=4 via R2; R1=1; LOAD R0,2; SUB R0,R1; STORE R0,9; LOAD R3,9; HALT
    vecs[1].prog[0] = enc(3'b100, 3'd2, 3'd0, 7'd4);
    vecs[1].prog[1] = enc(3'b011, 3'd2, 3'd0, 7'd2);
    vecs[1].prog[2] = enc(3'b100, 3'd1, 3'd0, 7'd1);
    vecs[1].prog[3] = enc(3'b010, 3'd0, 3'd0, 7'd2);
    vecs[1].prog[4] = enc(3'b001, 3'd0, 3'd1, 7'd0);
    vecs[1].prog[5] = enc(3'b011, 3'd0, 3'd0, 7'd9);
    vecs[1].prog[6] = enc(3'b010, 3'd3, 3'd0, 7'd9);
    vecs[1].prog[7] = HALT;
    vecs[1].exp_r   = {8'h03, 8'h04, 8'h01, 8'h03};
    vecs[1].exp_ret = 16'd7;
    vecs[1].exp_cyc = 8'd0;
    // R2 -> 0xFF; R3=R2; R2+1 wraps to 0; R1=1; R0=0-1 -> 0xFF
    vecs[2].prog[0] = enc(3'b100, 3'd2, 3'd0, 7'd127);
    vecs[2].prog[1] = enc(3'b100, 3'd2, 3'd0, 7'd127);
    vecs[2].prog[2] = enc(3'b100, 3'd2, 3'd0, 7'd1);
    vecs[2].prog[3] = enc(3'b000, 3'd3, 3'd2, 7'd0);
    vecs[2].prog[4] = enc(3'b100, 3'd2, 3'd0, 7'd1);
    vecs[2].prog[5] = enc(3'b100, 3'd1, 3'd0, 7'd1);
    vecs[2].prog[6] = enc(3'b001, 3'd0, 3'd1, 7'd0);
    vecs[2].prog[7] = HALT;
    vecs[2].exp_r   = {8'hFF, 8'h00, 8'h01, 8'hFF};
    vecs[2].exp_ret = 16'd7;
    vecs[2].exp_cyc = 8'd0;

    // ---- reset state ----
    do_reset();
    #1;
    chk("rst_pc", {28'b0, pc}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_retired", {16'b0, retired}, 32'd0);
    for (int r = 0; r < 4; r++) begin
      rd_reg(r, v);
      chk($sformatf("rst_R%0d", r), {24'b0, v}, 32'd0);
    end

    // ---- table-driven programs ----
    for (int k = 0; k < 3; k++) begin
      do_reset();
      load_prog(vecs[k].prog);
      run_to_halt(n);
      chk($sformatf("v%0d_halted", k), {31'b0, halted}, 32'd1);
      if (vecs[k].exp_cyc != 0)
        chk($sformatf("v%0d_cycles", k), n, {24'b0, vecs[k].exp_cyc});
      for (int r = 0; r < 4; r++) begin
        rd_reg(r, v);
        chk($sformatf("v%0d_R%0d", k, r), {24'b0, v}, {24'b0, vecs[k].exp_r[r]});
      end
      chk($sformatf("v%0d_retired", k), {16'b0, retired}, {16'b0, vecs[k].exp_ret});
      drop_run($sformatf("v%0d", k));
    end

    // Registers survive HALT->IDLE; out-of-range debug select reads 0.
    rd_reg(0, v);
    chk("kept_R0", {24'b0, v}, 32'hFF);
    rd_reg(4, v);
    chk("dbg_oob", {24'b0, v}, 32'd0);

    // ---- NOP stream: pc wrap, retire count, imem_we ignored in RUN ----
    do_reset();
    load_prog({8{NOP}});
    @(negedge clk);
    run = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      imem_we = (i == 2);
      imem_waddr = 4'd3;
      imem_wdata = enc(3'b100, 3'd1, 3'd0, 7'd1);
      if (i == 16) chk("wrap_pc15", {28'b0, pc}, 32'd15);
      if (i == 17) chk("wrap_pc0", {28'b0, pc}, 32'd0);
      if (i == 19) chk("nop_ret15", {16'b0, retired}, 32'd15);
      if (i == 20) chk("nop_ret16", {16'b0, retired}, 32'd16);
    end
    imem_we = 1'b0;
    chk("nop_halted", {31'b0, halted}, 32'd0);
    rd_reg(1, v);
    chk("run_we_ignored_R1", {24'b0, v}, 32'd0);
    drop_run("nop");

    // ---- reset pulse mid-RUN ----
    do_reset();
    begin
      logic [7:0][15:0] p;
      p = {8{NOP}};
      p[0] = enc(3'b100, 3'd1, 3'd0, 7'd5);
      p[1] = enc(3'b100, 3'd2, 3'd0, 7'd7);
      p[2] = enc(3'b000, 3'd1, 3'd2, 7'd0);
      p[3] = HALT;
      load_prog(p);
    end
    @(negedge clk);
    run = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    rd_reg(1, v);
    chk("mid_R1", {24'b0, v}, 32'd5);
    rd_reg(2, v);
    chk("mid_R2", {24'b0, v}, 32'd7);
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    chk("arst_pc", {28'b0, pc}, 32'd0);
    chk("arst_halted", {31'b0, halted}, 32'd0);
    chk("arst_retired", {16'b0, retired}, 32'd0);
    for (int r = 0; r < 4; r++) begin
      rd_reg(r, v);
      chk($sformatf("arst_R%0d", r), {24'b0, v}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Same program again: proves instruction memory survived the reset.
    run_to_halt(n);
    chk("rerun_halted", {31'b0, halted}, 32'd1);
    rd_reg(1, v);
    chk("rerun_R1", {24'b0, v}, 32'd12);
    rd_reg(2, v);
    chk("rerun_R2", {24'b0, v}, 32'd7);
    chk("rerun_retired", {16'b0, retired}, 32'd3);
    drop_run("rerun");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_pipe_core.md
PARAM_PIPE_CORE -- requirements
Module: param_pipe_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8: register and data-memory word width, legal range 8..32.
REQ-002 SHALL have parameter NUM_REGS, default 4: register-file depth, legal range 2..8.
REQ-003 SHALL have parameter IMEM_DEPTH, default 16: instruction words, power of 2, at most 128.
REQ-004 SHALL have parameter DMEM_DEPTH, default 16: data words, power of 2, at most 128.
REQ-005 SHALL have ports, clock and reset first (width is bits):
  clk  in  1  single clock, all state on rising edge
  rst_n  in  1  asynchronous active-low reset
  run  in  1  level; 1 = execute program, 0 = idle/program-load
  imem_we  in  1  instruction write strobe, honoured only in IDLE
  imem_waddr  in  log2(IMEM_DEPTH)  instruction write address
  imem_wdata  in  16  instruction word
  dbg_raddr  in  3  debug register select
  dbg_rdata  out  DATA_W  combinational reg_file[dbg_raddr]; 0 when dbg_raddr >= NUM_REGS
  pc  out  log2(IMEM_DEPTH)  fetch address
  halted  out  1  core in HALT state
  retired  out  16  count of retired non-bubble instructions

Function
REQ-006 SHALL decode each instruction as opcode[15:13], rd[12:10], rs[9:7], imm[6:0].
REQ-007 SHALL implement opcodes: 000 ADD rd=rd+rs; 001 SUB rd=rd-rs; 010 LOAD rd=dmem[imm]; 011 STORE dmem[imm]=rd; 100 ADDI rd=rd+zero-extended imm; 111 HALT; all others NOP.
REQ-008 SHALL wrap arithmetic modulo 2^DATA_W; imm SHALL be truncated modulo DMEM_DEPTH when used as an address; rd/rs >= NUM_REGS SHALL make the instruction a NOP.
REQ-009 SHALL use a 4-stage pipeline: IF, ID (operand read), EX (ALU, data-memory read, STORE write), WB (register write).
REQ-010 SHALL give a register written in WB a write-through bypass, so that ID reads the new value in the same cycle.
REQ-011 SHALL use FSM states IDLE, RUN, HALT: IDLE->RUN when run=1; RUN->HALT the cycle after HALT reaches EX; HALT->IDLE when run=0; RUN->IDLE when run=0 (pipeline flushed, registers kept).
REQ-012 SHALL advance pc by 1 per non-stalled RUN cycle, wrapping IMEM_DEPTH-1 -> 0; pc SHALL return to 0 on entering IDLE.
REQ-013 SHALL squash IF and ID contents to bubbles when HALT is in EX; instructions older than HALT SHALL complete WB.
REQ-014 SHALL increment retired once per instruction leaving WB, excluding bubbles and HALT, saturating at 0xFFFF and clearing on IDLE->RUN.
REQ-015 SHALL treat RAW hazards as ID source (rd, or rs for ADD/SUB) matching the destination of a writing instruction in EX or WB.
REQ-016 SHALL, for STORE in EX with LOAD of the same address in ID, have the LOAD observe the stored value.

Reset
REQ-017 SHALL, while rst_n=0: state=IDLE, pc=0, pipeline registers bubbles, all registers 0, halted=0, retired=0; instruction and data memory SHALL be unaffected.
REQ-018 SHALL abort an in-flight program without completing any write when rst_n is asserted mid-RUN.

Configuration
REQ-019 SHALL, when macro PIPE_CORE_FWD_EN is defined, forward the EX result and WB result into ID operands, priority EX over WB, with no stall cycles.
REQ-020 SHALL, without PIPE_CORE_FWD_EN, on a REQ-015 hazard hold pc and IF/ID and inject a bubble into EX until the hazard clears (max 2 stall cycles).

Verification
REQ-021 SHALL cover: load imem {ADDI R1,5; ADDI R1,3; HALT}, run=1 -> R1=8, halted=1, retired=2; stall cycles 0 with FWD_EN, 2 without.
REQ-022 SHALL cover: dmem[2]=4, program {LOAD R0,2; SUB R0,R1 (R1=1); STORE R0,9} -> dmem[9]=3.
REQ-023 SHALL cover: DATA_W=8, R2=0xFF, ADDI R2,1 -> R2=0x00; SUB 0-1 -> 0xFF.
REQ-024 SHALL cover: 16 NOPs with no HALT -> pc wraps 15->0, retired=16 after the 16th retirement.
REQ-025 SHALL cover: rst_n pulsed low mid-RUN -> all registers 0, pc=0, halted=0, imem contents intact.
REQ-026 SHALL cover: imem_we in RUN -> ignored; run dropped in HALT -> IDLE, pc=0, halted=0.
